// File: rtl/ringer_cadence_ctrl.sv
// Purpose : drives the ringer and vibration motor with an on/off cadence while a call is incoming.
//           It tracks missed calls in a saturating counter.
// Latency : ring sampled high in IDLE at edge t gives alert outputs from cycle t+1. The outputs are
//           a Moore decode of the state gated by the live alert mode.
// Backpr. : none. The inputs are level/pulse controls, and the outputs are continuous drive levels.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   mode[1:0]           0=SILENT 1=VIBRATE 2=RING 3=BOTH (bit1 = ringer, bit0 = motor)
//   ring                high while a call is incoming
//   answer              single-cycle answer pulse
//   missed_clear        single-cycle pulse that clears missed_count
//   turn_on_ringer      ringer drive
//   turn_on_motor       motor drive
//   ringing             high in the ON or OFF state
//   missed_count        saturating missed-call count
//
// Optional build macro: RINGER_CADENCE_CTRL_ESCALATE_EN. When it is defined, VIBRATE calls escalate
// to the ringer once ESC_RINGS on/off periods have completed.
module ringer_cadence_ctrl #(
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 2,
  parameter int MAX_RINGS  = 3,
  parameter int CNT_WIDTH  = 4,
  parameter int ESC_RINGS  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic                 ring,
  input  logic                 answer,
  input  logic                 missed_clear,
  output logic                 turn_on_ringer,
  output logic                 turn_on_motor,
  output logic                 ringing,
  output logic [CNT_WIDTH-1:0] missed_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;
  localparam logic [1:0] ST_WAIT = 2'd3;

  localparam int MAX_PER  = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CYC_W    = (MAX_PER > 1) ? $clog2(MAX_PER) : 1;
  // The ring counter must be wide enough for both the miss threshold and the escalation threshold.
  localparam int RING_TOP = (MAX_RINGS > ESC_RINGS) ? MAX_RINGS : ESC_RINGS;
  localparam int RC_W     = $clog2(RING_TOP + 1);

  logic [1:0]       state, state_nxt;
  logic [CYC_W-1:0] cyc_cnt, cyc_nxt;
  logic [RC_W-1:0]  ring_cnt, ring_nxt;
  logic             miss;
  logic             on_last, off_last;

  assign on_last  = (cyc_cnt == CYC_W'(ON_CYCLES - 1));
  assign off_last = (cyc_cnt == CYC_W'(OFF_CYCLES - 1));

  // Next-state logic. In ON and OFF, answer has priority over a ring drop, and a ring drop has
  // priority over the cadence timer.
  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc_cnt;
    ring_nxt  = ring_cnt;
    miss      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ring) begin
          if (answer) begin
            state_nxt = ST_WAIT;
          end else begin
            state_nxt = ST_ON;
            cyc_nxt   = '0;
            ring_nxt  = '0;
          end
        end
      end
      ST_ON: begin
        if (answer) begin
          state_nxt = ST_WAIT;
        end else if (!ring) begin
          state_nxt = ST_IDLE;
          miss      = 1'b1;
        end else if (on_last) begin
          state_nxt = ST_OFF;
          cyc_nxt   = '0;
        end else begin
          cyc_nxt = cyc_cnt + CYC_W'(1);
        end
      end
      ST_OFF: begin
        if (answer) begin
          state_nxt = ST_WAIT;
        end else if (!ring) begin
          state_nxt = ST_IDLE;
          miss      = 1'b1;
        end else if (off_last) begin
          ring_nxt = ring_cnt + RC_W'(1);
          if (ring_nxt == RC_W'(MAX_RINGS)) begin
            state_nxt = ST_WAIT;
            miss      = 1'b1;
          end else begin
            state_nxt = ST_ON;
            cyc_nxt   = '0;
          end
        end else begin
          cyc_nxt = cyc_cnt + CYC_W'(1);
        end
      end
      ST_WAIT: begin
        // A new call needs ring to fall first. The answer input is ignored in this state.
        if (!ring) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cyc_cnt  <= '0;
      ring_cnt <= '0;
    end else begin
      state    <= state_nxt;
      cyc_cnt  <= cyc_nxt;
      ring_cnt <= ring_nxt;
    end
  end

  // When a clear coincides with a miss, the counter lands on 1 so that the new miss is not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      missed_count <= '0;
    end else if (missed_clear) begin
      missed_count <= CNT_WIDTH'(miss);
    end else if (miss && !(&missed_count)) begin
      missed_count <= missed_count + CNT_WIDTH'(1);
    end
  end

  logic on_st;
  assign on_st = (state == ST_ON);

`ifdef RINGER_CADENCE_CTRL_ESCALATE_EN
  logic esc_active;
  assign esc_active     = (mode == 2'b01) && (32'(ring_cnt) >= 32'(ESC_RINGS));
  assign turn_on_ringer = on_st & (mode[1] | esc_active);
`else
  assign turn_on_ringer = on_st & mode[1];
`endif
  assign turn_on_motor  = on_st & mode[0];
  assign ringing        = on_st | (state == ST_OFF);

endmodule

// File: tb/tb_ringer_cadence_ctrl.sv
// Purpose : self-checking directed bench for ringer_cadence_ctrl.
//           It uses a default instance, plus a CNT_WIDTH=2 instance for saturation.
// Latency : inputs are driven 1 time unit after each rising edge. Outputs are sampled at that same
//           point, so cycle n is the state after the n-th edge of a scenario.
// Backpr. : not applicable.
module tb_ringer_cadence_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode = 2'd2;
  logic       ring = 1'b0;
  logic       answer = 1'b0;
  logic       missed_clear = 1'b0;

  logic       turn_on_ringer, turn_on_motor, ringing;
  logic [3:0] missed_count;
  logic       w2_ringer, w2_motor, w2_ringing;
  logic [1:0] w2_missed;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ringer_cadence_ctrl dut (
    .clk(clk), .reset(reset), .mode(mode), .ring(ring), .answer(answer),
    .missed_clear(missed_clear), .turn_on_ringer(turn_on_ringer),
    .turn_on_motor(turn_on_motor), .ringing(ringing), .missed_count(missed_count)
  );

  ringer_cadence_ctrl #(.CNT_WIDTH(2)) dut_w2 (
    .clk(clk), .reset(reset), .mode(mode), .ring(ring), .answer(answer),
    .missed_clear(missed_clear), .turn_on_ringer(w2_ringer),
    .turn_on_motor(w2_motor), .ringing(w2_ringing), .missed_count(w2_missed)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Resets the DUT. On return, cycle 0 of the next scenario has begun and the DUT is in IDLE.
  task automatic do_reset();
    reset = 1'b1; ring = 1'b0; answer = 1'b0; missed_clear = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    mode = 2'd3;
    do_reset();
    checks++;
    if ({turn_on_ringer, turn_on_motor, ringing} !== 3'b000 || missed_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_state got r/m/rg=%b%b%b cnt=%0d exp 000 cnt=0",
               turn_on_ringer, turn_on_motor, ringing, missed_count);
    end
  endtask

  // In mode RING with ring held high, the call runs the full cadence and then lands in WAIT as a miss.
  task automatic test_ring_cadence();
    logic exp_r;
    mode = 2'd2;
    do_reset();
    ring = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      exp_r = (c >= 1 && c <= 4) || (c >= 7 && c <= 10) || (c >= 13 && c <= 16);
      checks++;
      if (turn_on_ringer !== exp_r || turn_on_motor !== 1'b0 || ringing !== (c <= 18)) begin
        errors++;
        $display("FAIL cadence c=%0d got r/m/rg=%b%b%b exp %b0%b",
                 c, turn_on_ringer, turn_on_motor, ringing, exp_r, (c <= 18));
      end
      checks++;
      if (missed_count !== ((c >= 19) ? 4'd1 : 4'd0)) begin
        errors++;
        $display("FAIL cadence_missed c=%0d got %0d exp %0d", c, missed_count, (c >= 19) ? 1 : 0);
      end
    end
  endtask

  // In mode VIBRATE, an answer during OFF stops the alert with no miss and no restart while ring stays high.
  task automatic test_answer();
    mode = 2'd1;
    do_reset();
    ring = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      checks++;
      if (turn_on_motor !== (c <= 4) || turn_on_ringer !== 1'b0) begin
        errors++;
        $display("FAIL answer_motor c=%0d got m=%b r=%b exp m=%b r=0",
                 c, turn_on_motor, turn_on_ringer, (c <= 4));
      end
      if (c >= 7) begin
        checks++;
        if (ringing !== 1'b0 || missed_count !== 4'd0) begin
          errors++;
          $display("FAIL answer_stop c=%0d got rg=%b cnt=%0d exp rg=0 cnt=0", c, ringing, missed_count);
        end
      end
      answer = (c == 6);
    end
    answer = 1'b0;
    ring = 1'b0;
    step();
    ring = 1'b1;
    step();
    checks++;
    if (turn_on_motor !== 1'b1 || ringing !== 1'b1) begin
      errors++;
      $display("FAIL answer_restart got m=%b rg=%b exp m=1 rg=1", turn_on_motor, ringing);
    end
  endtask

  // An answer arriving together with ring in IDLE goes straight to WAIT.
  task automatic test_answer_idle();
    mode = 2'd3;
    do_reset();
    ring = 1'b1;
    answer = 1'b1;
    step();
    answer = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (ringing !== 1'b0 || turn_on_ringer !== 1'b0 || turn_on_motor !== 1'b0) begin
        errors++;
        $display("FAIL answer_idle c=%0d got r/m/rg=%b%b%b exp 000",
                 c, turn_on_ringer, turn_on_motor, ringing);
      end
      step();
    end
  endtask

  // In mode BOTH, a ring drop in cycle 3 stops the alert and counts a miss.
  task automatic test_ring_drop();
    mode = 2'd3;
    do_reset();
    ring = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      checks++;
      if (turn_on_ringer !== (c <= 3) || turn_on_motor !== (c <= 3)) begin
        errors++;
        $display("FAIL drop_out c=%0d got r=%b m=%b exp %b", c, turn_on_ringer, turn_on_motor, (c <= 3));
      end
      checks++;
      if (missed_count !== ((c >= 4) ? 4'd1 : 4'd0)) begin
        errors++;
        $display("FAIL drop_missed c=%0d got %0d exp %0d", c, missed_count, (c >= 4) ? 1 : 0);
      end
      if (c == 3) ring = 1'b0;
    end
  endtask

  // Back-to-back missed calls saturate the 2-bit counter. A clear coinciding with a miss yields 1.
  task automatic test_back_to_back();
    logic [1:0] exp_w2 [5];
    exp_w2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    mode = 2'd0;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      ring = 1'b1;
      step();
      ring = 1'b0;
      step();
      checks++;
      if (w2_missed !== exp_w2[k] || missed_count !== 4'(k + 1)) begin
        errors++;
        $display("FAIL sat_count call=%0d got w2=%0d w4=%0d exp w2=%0d w4=%0d",
                 k + 1, w2_missed, missed_count, exp_w2[k], k + 1);
      end
    end
    ring = 1'b1;
    step();
    ring = 1'b0;
    missed_clear = 1'b1;
    step();
    missed_clear = 1'b0;
    checks++;
    if (w2_missed !== 2'd1 || missed_count !== 4'd1) begin
      errors++;
      $display("FAIL clear_with_miss got w2=%0d w4=%0d exp 1", w2_missed, missed_count);
    end
    missed_clear = 1'b1;
    step();
    missed_clear = 1'b0;
    checks++;
    if (w2_missed !== 2'd0) begin
      errors++;
      $display("FAIL clear_only got %0d exp 0", w2_missed);
    end
  endtask

  // A reset in cycle 8 mid-call clears everything in cycle 9, and the call restarts in cycle 10.
  task automatic test_mid_reset();
    mode = 2'd3;
    do_reset();
    ring = 1'b1;
    for (int c = 1; c <= 8; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({turn_on_ringer, turn_on_motor, ringing} !== 3'b000 || missed_count !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset got r/m/rg=%b%b%b cnt=%0d exp 000 cnt=0",
               turn_on_ringer, turn_on_motor, ringing, missed_count);
    end
    step();
    checks++;
    if ({turn_on_ringer, turn_on_motor, ringing} !== 3'b111) begin
      errors++;
      $display("FAIL mid_reset_restart got r/m/rg=%b%b%b exp 111",
               turn_on_ringer, turn_on_motor, ringing);
    end
  endtask

  // In mode VIBRATE, the ringer joins the motor in the third ON period only when escalation is built in.
  task automatic test_escalate();
    logic on_c, exp_r;
    mode = 2'd1;
    do_reset();
    ring = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      on_c = ((c - 1) % 6) < 4;
`ifdef RINGER_CADENCE_CTRL_ESCALATE_EN
      exp_r = on_c && (c >= 13);
`else
      exp_r = 1'b0;
`endif
      checks++;
      if (turn_on_ringer !== exp_r || turn_on_motor !== on_c) begin
        errors++;
        $display("FAIL escalate c=%0d got r=%b m=%b exp r=%b m=%b",
                 c, turn_on_ringer, turn_on_motor, exp_r, on_c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ring_cadence();
    test_answer();
    test_answer_idle();
    test_ring_drop();
    test_back_to_back();
    test_mid_reset();
    test_escalate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
